player_sprite_engine: RTL and testbench



---
 rtl/player_sprite_pkg.sv | 28 ++
 rtl/sprite_scan.sv | 54 +++++
 rtl/player_sprite_engine.sv | 191 +++++++++++++++++++
 tb/tb_player_sprite_engine.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/player_sprite_pkg.sv
// Shared types and constants for the player sprite engine: FSM states, poses
// and the three plotter colours.
package player_sprite_pkg;

    typedef enum logic [2:0] {
        S_INIT_DRAW,
        S_IDLE,
        S_CRAWL_HOLD,
        S_WAIT,
        S_ERASE,
        S_UPDATE,
        S_DRAW
    } state_t;

    typedef enum logic {
        POSE_STAND,
        POSE_CRAWL
    } pose_t;

    localparam logic [2:0] COL_BLACK  = 3'b000;
    localparam logic [2:0] COL_BORDER = 3'b101;
    localparam logic [2:0] COL_BODY   = 3'b110;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sprite_scan.sv
// Row-major raster counter shared by the erase and draw passes; done marks
// the last pixel of a width x height scan.
module sprite_scan #(
    parameter int DIM_W = 6
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [DIM_W-1:0] width,
    input  logic [DIM_W-1:0] height,
    output logic [DIM_W-1:0] col,
    output logic [DIM_W-1:0] row,
    output logic             busy,
    output logic             done
);
    localparam logic [DIM_W-1:0] ONE = DIM_W'(1);

    logic [DIM_W-1:0] col_reg, row_reg, w_reg, h_reg;
    logic             busy_reg;
    logic             last_col, last_row;

    assign last_col = (col_reg == w_reg - ONE);
    assign last_row = (row_reg == h_reg - ONE);

    always_ff @(posedge clock) begin
        if (reset) begin
            busy_reg <= 1'b0;
            col_reg  <= '0;
            row_reg  <= '0;
            w_reg    <= '0;
            h_reg    <= '0;
        end else if (start) begin
            busy_reg <= 1'b1;
            col_reg  <= '0;
            row_reg  <= '0;
            w_reg    <= width;
            h_reg    <= height;
        end else if (busy_reg) begin
            if (last_col) begin
                col_reg <= '0;
                if (last_row) busy_reg <= 1'b0;
                else          row_reg  <= row_reg + ONE;
            end else begin
                col_reg <= col_reg + ONE;
            end
        end
    end

    assign col  = col_reg;
    assign row  = row_reg;
    assign busy = busy_reg;
    assign done = busy_reg && last_col && last_row;

endmodule

// File: rtl/player_sprite_engine.sv
// Player sprite engine: pose/jump FSM streaming erase-then-draw pixel passes.
// Define PLAYER_DOUBLE_JUMP_EN to allow one re-jump per flight on the way down.
module player_sprite_engine
    import player_sprite_pkg::*;
#(
    parameter int X_W        = 8,
    parameter int Y_W        = 7,
    parameter int SPR_W      = 16,
    parameter int SPR_H      = 16,
    parameter int CRAWL_W    = 32,
    parameter int CRAWL_H    = 8,
    parameter int HOME_X     = 20,
    parameter int GROUND_Y   = 75,
    parameter int JUMP_H     = 30,
    parameter int STEP_TICKS = 250000
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           jump,
    input  logic           crawl,
    output logic [X_W-1:0] out_x,
    output logic [Y_W-1:0] out_y,
    output logic [2:0]     colour,
    output logic           plot,
    output logic [X_W-1:0] x,
    output logic [Y_W-1:0] y,
    output logic           airborne
);
    localparam int WAIT_N  = (STEP_TICKS < 1) ? 1 : STEP_TICKS;
    localparam int CNT_W   = (WAIT_N > 1) ? $clog2(WAIT_N) : 1;
    localparam int MAX_DIM = max2(max2(SPR_W, SPR_H), max2(CRAWL_W, CRAWL_H));
    localparam int DIM_W   = $clog2(MAX_DIM + 1);

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(WAIT_N - 1);
    localparam logic [Y_W-1:0]   GROUND    = Y_W'(GROUND_Y);
    localparam logic [Y_W-1:0]   JUMP      = Y_W'(JUMP_H);
    localparam logic [Y_W-1:0]   CRAWL_OFS = Y_W'(SPR_H - CRAWL_H);
    localparam logic [Y_W-1:0]   Y_ONE     = Y_W'(1);
    localparam logic [DIM_W-1:0] D_ONE     = DIM_W'(1);

    if (GROUND_Y < JUMP_H || GROUND_Y + SPR_H > (1 << Y_W)) begin : g_cfg_error
        $error("player_sprite_engine: jump/ground geometry does not fit in Y_W");
    end

    state_t           state_reg;
    pose_t            pose_reg, pose_next_reg;
    logic             pass_active_reg;
    logic [CNT_W-1:0] wait_cnt_reg;
    logic [X_W-1:0]   x_reg, out_x_reg;
    logic [Y_W-1:0]   y_reg, apex_reg, out_y_reg;
    logic             airborne_reg, dir_up_reg, jump_prev_reg;
    logic [2:0]       colour_reg;
    logic             plot_reg;

    logic             jump_rise, pass_state, scan_start, scan_busy, scan_done, ring;
    logic [DIM_W-1:0] cur_w, cur_h, scan_col, scan_row;
    logic [Y_W-1:0]   sprite_top, y_step;

    assign jump_rise  = jump & ~jump_prev_reg;
    assign pass_state = state_reg inside {S_INIT_DRAW, S_ERASE, S_DRAW};
    assign scan_start = pass_state & ~pass_active_reg;
    // Crawl pose is bottom-aligned with the standing sprite.
    assign cur_w      = (pose_reg == POSE_CRAWL) ? DIM_W'(CRAWL_W) : DIM_W'(SPR_W);
    assign cur_h      = (pose_reg == POSE_CRAWL) ? DIM_W'(CRAWL_H) : DIM_W'(SPR_H);
    assign sprite_top = (pose_reg == POSE_CRAWL) ? y_reg + CRAWL_OFS : y_reg;
    assign y_step     = dir_up_reg ? y_reg - Y_ONE : y_reg + Y_ONE;
    assign ring       = (scan_col == '0) || (scan_row == '0) ||
                        (scan_col == cur_w - D_ONE) || (scan_row == cur_h - D_ONE);

`ifdef PLAYER_DOUBLE_JUMP_EN
    logic           dj_flag_reg, dj_take, landing;
    logic [Y_W-1:0] dj_apex;
    assign dj_take = jump_rise && airborne_reg && !dir_up_reg && !dj_flag_reg;
    assign landing = (state_reg == S_UPDATE) && airborne_reg && !dir_up_reg && (y_step == GROUND);
    assign dj_apex = (y_reg >= JUMP) ? y_reg - JUMP : '0;
`endif

    sprite_scan #(.DIM_W(DIM_W)) u_scan (
        .clock  (clock),
        .reset  (reset),
        .start  (scan_start),
        .width  (cur_w),
        .height (cur_h),
        .col    (scan_col),
        .row    (scan_row),
        .busy   (scan_busy),
        .done   (scan_done)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg       <= S_INIT_DRAW;
            pose_reg        <= POSE_STAND;
            pose_next_reg   <= POSE_STAND;
            pass_active_reg <= 1'b0;
            wait_cnt_reg    <= '0;
            x_reg           <= X_W'(HOME_X);
            y_reg           <= GROUND;
            apex_reg        <= GROUND - JUMP;
            airborne_reg    <= 1'b0;
            dir_up_reg      <= 1'b0;
            jump_prev_reg   <= 1'b0;
            out_x_reg       <= '0;
            out_y_reg       <= '0;
            colour_reg      <= COL_BLACK;
            plot_reg        <= 1'b0;
`ifdef PLAYER_DOUBLE_JUMP_EN
            dj_flag_reg     <= 1'b0;
`endif
        end else begin
            jump_prev_reg <= jump;
            plot_reg      <= scan_busy;
            out_x_reg     <= x_reg + X_W'(scan_col);
            out_y_reg     <= sprite_top + Y_W'(scan_row);
            colour_reg    <= (state_reg == S_ERASE) ? COL_BLACK : (ring ? COL_BORDER : COL_BODY);

            case (state_reg)
                S_INIT_DRAW, S_ERASE, S_DRAW: begin
                    if (!pass_active_reg) begin
                        pass_active_reg <= 1'b1;
                    end else if (scan_done) begin
                        pass_active_reg <= 1'b0;
                        if (state_reg == S_ERASE)        state_reg <= S_UPDATE;
                        else if (airborne_reg)           state_reg <= S_WAIT;
                        else if (pose_reg == POSE_CRAWL) state_reg <= S_CRAWL_HOLD;
                        else                             state_reg <= S_IDLE;
                    end
                end
                S_IDLE: begin
                    if (jump_rise && !crawl) begin
                        airborne_reg <= 1'b1;
                        dir_up_reg   <= 1'b1;
                        apex_reg     <= GROUND - JUMP;
                        state_reg    <= S_WAIT;
                    end else if (crawl && !jump) begin
                        pose_next_reg <= POSE_CRAWL;
                        state_reg     <= S_ERASE;
                    end
                end
                S_CRAWL_HOLD: begin
                    if (!crawl) begin
                        pose_next_reg <= POSE_STAND;
                        state_reg     <= S_ERASE;
                    end
                end
                S_WAIT: begin
                    if (wait_cnt_reg == CNT_LAST) begin
                        wait_cnt_reg <= '0;
                        state_reg    <= S_ERASE;
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg + CNT_W'(1);
                    end
                end
                S_UPDATE: begin
                    pose_reg <= pose_next_reg;
                    if (airborne_reg) begin
                        y_reg <= y_step;
                        if (dir_up_reg) begin
                            if (y_step == apex_reg) dir_up_reg <= 1'b0;
                        end else if (y_step == GROUND) begin
                            airborne_reg <= 1'b0;
`ifdef PLAYER_DOUBLE_JUMP_EN
                            dj_flag_reg  <= 1'b0;
`endif
                        end
                    end
                    state_reg <= S_DRAW;
                end
                default: state_reg <= S_INIT_DRAW;
            endcase

`ifdef PLAYER_DOUBLE_JUMP_EN
            // Overrides any dir write above; an edge landing in UPDATE steers the next step.
            if (dj_take && !landing) begin
                dir_up_reg  <= 1'b1;
                apex_reg    <= dj_apex;
                dj_flag_reg <= 1'b1;
            end
`endif
        end
    end

    assign out_x    = out_x_reg;
    assign out_y    = out_y_reg;
    assign colour   = colour_reg;
    assign plot     = plot_reg;
    assign x        = x_reg;
    assign y        = y_reg;
    assign airborne = airborne_reg;

endmodule

// File: tb/tb_player_sprite_engine.sv
// Scoreboard bench for player_sprite_engine: expected pixels are queued from a
// footprint/trajectory model and popped by a monitor whenever plot is high.
module tb_player_sprite_engine;
    localparam int X_W = 8, Y_W = 7;
    localparam int SPR_W = 16, SPR_H = 16, CRAWL_W = 32, CRAWL_H = 8;
    localparam int HOME_X = 20, GROUND_Y = 75, JUMP_H = 30, STEP_TICKS = 4;
    localparam int PASS = SPR_W * SPR_H;
    localparam int STEP_CYC = STEP_TICKS + 2 * PASS + 3;

    logic           clock = 1'b0, reset = 1'b1, jump = 1'b0, crawl = 1'b0;
    logic [X_W-1:0] out_x, x;
    logic [Y_W-1:0] out_y, y;
    logic [2:0]     colour;
    logic           plot, airborne;

    player_sprite_engine #(
        .X_W(X_W), .Y_W(Y_W), .SPR_W(SPR_W), .SPR_H(SPR_H),
        .CRAWL_W(CRAWL_W), .CRAWL_H(CRAWL_H), .HOME_X(HOME_X),
        .GROUND_Y(GROUND_Y), .JUMP_H(JUMP_H), .STEP_TICKS(STEP_TICKS)
    ) dut (
        .clock(clock), .reset(reset), .jump(jump), .crawl(crawl),
        .out_x(out_x), .out_y(out_y), .colour(colour), .plot(plot),
        .x(x), .y(y), .airborne(airborne)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [X_W-1:0] px;
        logic [Y_W-1:0] py;
        logic [2:0]     pc;
    } pix_t;

    pix_t exp_q[$];
    pix_t e;
    int   n_cmp = 0, n_bad = 0, pops = 0, cyc = 0;
    int   first_plot = -1, last_plot = -1, fall_cyc = -1, fall_y = -1, min_y = 1000;
    logic airborne_q = 1'b0;

    initial forever begin
        @(posedge clock);
        cyc++;
    end

    initial forever begin
        @(negedge clock);
        if (plot) begin
            if (first_plot < 0) first_plot = cyc;
            last_plot = cyc;
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL stray_plot: got x=%0d y=%0d colour=%0d, required no plot", out_x, out_y, colour);
            end else begin
                e = exp_q.pop_front();
                pops++;
                if ({out_x, out_y, colour} !== e) begin
                    n_bad++;
                    $display("FAIL pixel: got x=%0d y=%0d colour=%0d, required x=%0d y=%0d colour=%0d",
                             out_x, out_y, colour, e.px, e.py, e.pc);
                end
            end
        end
        if (int'(y) < min_y) min_y = int'(y);
        if (airborne_q && !airborne) begin
            fall_cyc = cyc;
            fall_y   = int'(y);
        end
        airborne_q = airborne;
    end

    task automatic check(input string name, input int got, input int want);
        n_cmp++;
        if (got != want) begin
            n_bad++;
            $display("FAIL %s: got %0d, required %0d", name, got, want);
        end
    endtask

    task automatic check_tol(input string name, input int got, input int want, input int tol);
        n_cmp++;
        if (got < want - tol || got > want + tol) begin
            n_bad++;
            $display("FAIL %s: got %0d, required %0d +/- %0d", name, got, want, tol);
        end
    endtask

    // Footprint of one pass, row-major; ys is always the standing top row.
    task automatic push_pass(input bit crawl_pose, input int ys, input bit erase);
        int w, h, top;
        pix_t p;
        w   = crawl_pose ? CRAWL_W : SPR_W;
        h   = crawl_pose ? CRAWL_H : SPR_H;
        top = crawl_pose ? ys + SPR_H - CRAWL_H : ys;
        for (int r = 0; r < h; r++) begin
            for (int c = 0; c < w; c++) begin
                p.px = X_W'(HOME_X + c);
                p.py = Y_W'(top + r);
                if (erase)                                      p.pc = 3'b000;
                else if (r == 0 || r == h-1 || c == 0 || c == w-1) p.pc = 3'b101;
                else                                            p.pc = 3'b110;
                exp_q.push_back(p);
            end
        end
    endtask

    task automatic tick();
        @(negedge clock);
        #1;
    endtask

    task automatic arm();
        first_plot = -1;
        last_plot  = -1;
        fall_cyc   = -1;
        fall_y     = -1;
        min_y      = 1000;
    endtask

    task automatic drain(input string name, input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || plot) && n < budget) begin
            tick();
            n++;
        end
        if (n >= budget) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s_timeout: got %0d pixels outstanding, required 0", name, exp_q.size());
            exp_q.delete();
        end
        repeat (8) tick();
    endtask

    task automatic wait_pops(input string name, input int target, input int budget);
        int n = 0;
        while (pops < target && n < budget) begin
            tick();
            n++;
        end
        if (n >= budget) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s_timeout: got %0d pixels, required %0d", name, pops, target);
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got no finish, required finish");
        $fatal(1, "watchdog");
    end

    int c0, base, prev, steps, model_min, third_step;
    int traj[$];

    initial begin
        // Reset state
        repeat (3) tick();
        check("rst_plot", int'(plot), 0);
        check("rst_out_x", int'(out_x), 0);
        check("rst_out_y", int'(out_y), 0);
        check("rst_colour", int'(colour), 0);
        check("rst_x", int'(x), HOME_X);
        check("rst_y", int'(y), GROUND_Y);
        check("rst_airborne", int'(airborne), 0);

        // Initial stand draw
        push_pass(1'b0, GROUND_Y, 1'b0);
        arm();
        c0 = cyc;
        reset = 1'b0;
        drain("init", 2000);
        check("init_latency", first_plot - c0, 2);
        check("init_span", last_plot - first_plot + 1, PASS);

        // Crawl on, then off
        push_pass(1'b0, GROUND_Y, 1'b1);
        push_pass(1'b1, GROUND_Y, 1'b0);
        arm();
        c0 = cyc;
        crawl = 1'b1;
        drain("crawl_on", 3000);
        check("crawl_on_latency", first_plot - c0, 3);
        check("crawl_on_span", last_plot - first_plot + 1, 2 * PASS + 2);
        check("crawl_y", int'(y), GROUND_Y);
        repeat (10) tick();
        push_pass(1'b1, GROUND_Y, 1'b1);
        push_pass(1'b0, GROUND_Y, 1'b0);
        arm();
        c0 = cyc;
        crawl = 1'b0;
        drain("crawl_off", 3000);
        check("crawl_off_latency", first_plot - c0, 3);
        check("crawl_off_span", last_plot - first_plot + 1, 2 * PASS + 2);

        // Jump and crawl together in IDLE: nothing happens
        arm();
        jump = 1'b1;
        crawl = 1'b1;
        repeat (20) tick();
        jump = 1'b0;
        crawl = 1'b0;
        repeat (5) tick();
        check("both_no_plot", first_plot, -1);
        check("both_y", int'(y), GROUND_Y);
        check("both_airborne", int'(airborne), 0);

        // Full jump with extra jump edges while airborne
        traj.delete();
        for (int v = GROUND_Y - 1; v >= GROUND_Y - JUMP_H; v--) traj.push_back(v);
`ifdef PLAYER_DOUBLE_JUMP_EN
        for (int v = GROUND_Y - JUMP_H + 1; v <= 60; v++) traj.push_back(v);
        for (int v = 59; v >= 30; v--) traj.push_back(v);
        for (int v = 31; v <= GROUND_Y; v++) traj.push_back(v);
        third_step = 100;
`else
        for (int v = GROUND_Y - JUMP_H + 1; v <= GROUND_Y; v++) traj.push_back(v);
        third_step = 55;
`endif
        steps = traj.size();
        model_min = 1000;
        prev = GROUND_Y;
        foreach (traj[i]) begin
            push_pass(1'b0, prev, 1'b1);
            push_pass(1'b0, traj[i], 1'b0);
            if (traj[i] < model_min) model_min = traj[i];
            prev = traj[i];
        end
        arm();
        base = pops;
        c0 = cyc;
        jump = 1'b1;
        tick();
        jump = 1'b0;
        wait_pops("dj_point", base + 45 * 2 * PASS, 40000);
        check("dj_point_y", int'(y), 60);
        check("dj_point_airborne", int'(airborne), 1);
        jump = 1'b1;
        tick();
        jump = 1'b0;
        wait_pops("third_edge", base + third_step * 2 * PASS, 40000);
        jump = 1'b1;
        tick();
        jump = 1'b0;
        drain("jump", 80000);
        // +1: the jump edge is sampled one clock after it is driven
        check("jump_first_plot", first_plot - c0, STEP_TICKS + 2 + 1);
        check_tol("jump_total", last_plot - c0 - 1, steps * STEP_CYC, 2);
        check("jump_fall_time", fall_cyc - c0 - 1, (steps - 1) * STEP_CYC + STEP_TICKS + PASS + 2);
        check("jump_fall_y", fall_y, GROUND_Y);
        check("jump_min_y", min_y, model_min);
        check("jump_end_y", int'(y), GROUND_Y);
        check("jump_end_airborne", int'(airborne), 0);

        // Reset in the middle of a jump DRAW pass
        prev = GROUND_Y;
        for (int k = 1; k <= 3; k++) begin
            push_pass(1'b0, prev, 1'b1);
            push_pass(1'b0, GROUND_Y - k, 1'b0);
            prev = GROUND_Y - k;
        end
        jump = 1'b1;
        tick();
        jump = 1'b0;
        wait_pops("mid_draw", pops + 5 * PASS + PASS / 2, 5000);
        check("mid_airborne", int'(airborne), 1);
        check("mid_y", int'(y), GROUND_Y - 3);
        reset = 1'b1;
        tick();
        check("rst2_plot", int'(plot), 0);
        check("rst2_y", int'(y), GROUND_Y);
        check("rst2_x", int'(x), HOME_X);
        check("rst2_airborne", int'(airborne), 0);
        exp_q.delete();
        push_pass(1'b0, GROUND_Y, 1'b0);
        arm();
        c0 = cyc;
        reset = 1'b0;
        drain("reinit", 2000);
        check("reinit_latency", first_plot - c0, 2);
        check("reinit_span", last_plot - first_plot + 1, PASS);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
